// File: rtl/pcs_rx_pattern_checker.sv
// Receive-side fixed-pattern checker: hunts for alignment against a cyclic
// table of data words, verifies, then counts block and bit errors while locked.
module pcs_rx_pattern_checker #(
   parameter int                   DATA_WIDTH      = 64,
   parameter int                   HDR_WIDTH       = 2,
   parameter int                   NUM_PATTERNS    = 8,
   parameter logic [HDR_WIDTH-1:0] HDR_EXPECTED    = 2'b01,
   parameter int                   LOCK_GOOD       = 4,
   parameter int                   LOCK_BAD        = 4,
   parameter int                   ERR_COUNT_WIDTH = 16
) (
   input  logic                                      rx_clk,
   input  logic                                      rx_rst,
   input  logic                                      cfg_enable,
   input  logic [$clog2(NUM_PATTERNS):0]             cfg_pattern_count,
   input  logic [NUM_PATTERNS*DATA_WIDTH-1:0]        cfg_patterns,
   input  logic                                      clear_counts,
   input  logic [DATA_WIDTH-1:0]                     rx_data,
   input  logic [HDR_WIDTH-1:0]                      rx_hdr,
   input  logic                                      rx_valid,
   output logic                                      pattern_lock,
   output logic                                      pattern_error,
   output logic [$clog2(NUM_PATTERNS)-1:0]           expected_index,
   output logic [ERR_COUNT_WIDTH-1:0]                block_error_count,
   output logic [ERR_COUNT_WIDTH-1:0]                bit_error_count
);

   localparam int IDX_W = $clog2(NUM_PATTERNS);
   localparam int N_W   = IDX_W + 1;
   localparam int GC_W  = $clog2(LOCK_GOOD + 1);
   localparam int BC_W  = $clog2(LOCK_BAD + 1);
   localparam int PC_W  = $clog2(DATA_WIDTH + HDR_WIDTH + 1);
   localparam int SUM_W = ((ERR_COUNT_WIDTH > PC_W) ? ERR_COUNT_WIDTH : PC_W) + 1;

   typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

   state_t                     state_q, state_d;
   logic [IDX_W-1:0]           exp_idx_q, exp_idx_d;
   logic [GC_W-1:0]            good_q, good_d;
   logic [BC_W-1:0]            bad_q, bad_d;
   logic                       err_q, err_d;
   logic [ERR_COUNT_WIDTH-1:0] blk_q, blk_d;
   logic [ERR_COUNT_WIDTH-1:0] bit_q, bit_d;

   logic [N_W-1:0]             n_eff;
   logic [IDX_W-1:0]           cur_idx;
   logic [DATA_WIDTH-1:0]      exp_word;
   logic                       hdr_ok, match, hit;
   logic [IDX_W-1:0]           hit_idx;
   logic [SUM_W-1:0]           bit_sum;

   function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i,
                                                input logic [N_W-1:0]   n);
      logic [N_W-1:0] p;
      p = N_W'(i) + N_W'(1);
      return (p >= n) ? '0 : p[IDX_W-1:0];
   endfunction

   function automatic logic [PC_W-1:0] popc(input logic [DATA_WIDTH+HDR_WIDTH-1:0] v);
      logic [PC_W-1:0] c;
      c = '0;
      for (int i = 0; i < DATA_WIDTH + HDR_WIDTH; i++) c = c + PC_W'(v[i]);
      return c;
   endfunction

   // Clamp table length to [1, NUM_PATTERNS]; a stale index past a shrunk table restarts at 0.
   always_comb begin
      if (cfg_pattern_count == '0)                    n_eff = N_W'(1);
      else if (cfg_pattern_count > N_W'(NUM_PATTERNS)) n_eff = N_W'(NUM_PATTERNS);
      else                                            n_eff = cfg_pattern_count;
      cur_idx  = (N_W'(exp_idx_q) >= n_eff) ? '0 : exp_idx_q;
      exp_word = cfg_patterns[cur_idx*DATA_WIDTH +: DATA_WIDTH];
      hdr_ok   = (rx_hdr == HDR_EXPECTED);
      match    = hdr_ok && (rx_data == exp_word);
   end

   // Alignment search: scan downwards so the lowest matching index wins.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int k = NUM_PATTERNS - 1; k >= 0; k--) begin
         if ((N_W'(k) < n_eff) && (cfg_patterns[k*DATA_WIDTH +: DATA_WIDTH] == rx_data)) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(k);
         end
      end
   end

   // State register.
   always_ff @(posedge rx_clk) begin
      if (rx_rst) state_q <= HUNT;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      if (!cfg_enable) begin
         state_d = HUNT;
      end else if (rx_valid) begin
         case (state_q)
            HUNT:    if (hdr_ok && hit) state_d = (LOCK_GOOD <= 1) ? LOCKED : VERIFY;
            VERIFY:  if (!match)                                  state_d = HUNT;
                     else if (32'(good_q) + 1 >= LOCK_GOOD)       state_d = LOCKED;
            LOCKED:  if (!match && (32'(bad_q) + 1 >= LOCK_BAD)) state_d = HUNT;
            default: state_d = HUNT;
         endcase
      end
   end

   // Datapath / output next values: index, run counters, error pulse, saturating counters.
   always_comb begin
      exp_idx_d = exp_idx_q;
      good_d    = good_q;
      bad_d     = bad_q;
      err_d     = 1'b0;
      blk_d     = blk_q;
      bit_d     = bit_q;
      bit_sum   = SUM_W'(bit_q) + SUM_W'(popc({rx_data ^ exp_word, rx_hdr ^ HDR_EXPECTED}));
      if (!cfg_enable) begin
         good_d = '0;
         bad_d  = '0;
      end else if (rx_valid) begin
         case (state_q)
            HUNT: begin
               bad_d = '0;
               if (hdr_ok && hit) begin
                  exp_idx_d = idx_inc(hit_idx, n_eff);
                  good_d    = GC_W'(1);
               end
            end
            VERIFY: begin
               bad_d = '0;
               if (match) begin
                  exp_idx_d = idx_inc(cur_idx, n_eff);
                  good_d    = good_q + GC_W'(1);
               end else begin
                  good_d = '0;
               end
            end
            LOCKED: begin
               exp_idx_d = idx_inc(cur_idx, n_eff);
               good_d    = '0;
               if (match) begin
                  bad_d = '0;
               end else begin
                  err_d = 1'b1;
                  bad_d = (32'(bad_q) + 1 >= LOCK_BAD) ? '0 : bad_q + BC_W'(1);
                  if (blk_q != '1) blk_d = blk_q + ERR_COUNT_WIDTH'(1);
                  bit_d = (bit_sum > SUM_W'({ERR_COUNT_WIDTH{1'b1}})) ? '1
                                                                        : bit_sum[ERR_COUNT_WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
      // Clear beats a same-cycle error; the pulse is still reported.
      if (clear_counts) begin
         blk_d = '0;
         bit_d = '0;
      end
   end

   // Datapath registers.
   always_ff @(posedge rx_clk) begin
      if (rx_rst) begin
         exp_idx_q <= '0;
         good_q    <= '0;
         bad_q     <= '0;
         err_q     <= 1'b0;
         blk_q     <= '0;
         bit_q     <= '0;
      end else begin
         exp_idx_q <= exp_idx_d;
         good_q    <= good_d;
         bad_q     <= bad_d;
         err_q     <= err_d;
         blk_q     <= blk_d;
         bit_q     <= bit_d;
      end
   end

   assign pattern_lock      = (state_q == LOCKED);
   assign pattern_error     = err_q;
   assign expected_index    = exp_idx_q;
   assign block_error_count = blk_q;
   assign bit_error_count   = bit_q;

endmodule

// File: tb/tb_pcs_rx_pattern_checker.sv
// Directed bench: lock, single/multi-bit errors, stall, lock loss and relock,
// enable drop, mid-run reset, and counter saturation on a narrow-counter instance.
module tb_pcs_rx_pattern_checker;

   logic          rx_clk = 1'b0;
   logic          rx_rst, cfg_enable, clear_counts, rx_valid;
   logic [3:0]    cfg_pattern_count;
   logic [511:0]  cfg_patterns;
   logic [63:0]   rx_data;
   logic [1:0]    rx_hdr;

   logic          lock, perr;
   logic [2:0]    idx;
   logic [15:0]   blk, bits;
   logic          s_lock, s_perr;
   logic [2:0]    s_idx;
   logic [3:0]    s_blk, s_bits;

   logic [63:0]   pat [8];
   int            ph;
   int            exp_blk, exp_bits;
   int            errs = 0, checks = 0;

   always #5 rx_clk = ~rx_clk;

   pcs_rx_pattern_checker u_dut (
      .rx_clk(rx_clk), .rx_rst(rx_rst), .cfg_enable(cfg_enable),
      .cfg_pattern_count(cfg_pattern_count), .cfg_patterns(cfg_patterns),
      .clear_counts(clear_counts), .rx_data(rx_data), .rx_hdr(rx_hdr), .rx_valid(rx_valid),
      .pattern_lock(lock), .pattern_error(perr), .expected_index(idx),
      .block_error_count(blk), .bit_error_count(bits));

   pcs_rx_pattern_checker #(.ERR_COUNT_WIDTH(4), .LOCK_BAD(32)) u_sat (
      .rx_clk(rx_clk), .rx_rst(rx_rst), .cfg_enable(cfg_enable),
      .cfg_pattern_count(cfg_pattern_count), .cfg_patterns(cfg_patterns),
      .clear_counts(clear_counts), .rx_data(rx_data), .rx_hdr(rx_hdr), .rx_valid(rx_valid),
      .pattern_lock(s_lock), .pattern_error(s_perr), .expected_index(s_idx),
      .block_error_count(s_blk), .bit_error_count(s_bits));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock with the given word presented; outputs are sampled 1 time unit after the edge.
   task automatic step(input logic [63:0] d, input logic [1:0] h, input logic v);
      rx_data  = d;
      rx_hdr   = h;
      rx_valid = v;
      @(posedge rx_clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_good();
      step(pat[ph], 2'b01, 1'b1);
      ph = (ph + 1) % 6;
   endtask

   // Errored word in place of pat[ph]; tracks what the main instance should count.
   task automatic send_err(input logic [63:0] d, input logic [1:0] h);
      exp_blk++;
      exp_bits += $countones(d ^ pat[ph]) + $countones(h ^ 2'b01);
      step(d, h, 1'b1);
      ph = (ph + 1) % 6;
   endtask

   initial begin
      pat[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      pat[1] = 64'h0000_0000_0000_0000;
      pat[2] = 64'h5555_5555_5555_5555;
      pat[3] = 64'hAAAA_AAAA_AAAA_AAAA;
      pat[4] = 64'hFEFE_FEFE_FEFE_FEFE;
      pat[5] = 64'h0707_0707_0707_0707;
      pat[6] = 64'h0123_4567_89AB_CDEF;
      pat[7] = 64'h0123_4567_89AB_CDEF;
      for (int k = 0; k < 8; k++) cfg_patterns[k*64 +: 64] = pat[k];
      cfg_pattern_count = 4'd6;
      cfg_enable   = 1'b1;
      clear_counts = 1'b0;
      rx_valid     = 1'b0;
      rx_data      = '0;
      rx_hdr       = 2'b01;
      exp_blk      = 0;
      exp_bits     = 0;
      rx_rst       = 1'b1;
      repeat (2) @(posedge rx_clk);
      #1;
      rx_rst = 1'b0;

      // reset state
      chk("rst_lock", lock, 0);
      chk("rst_err", perr, 0);
      chk("rst_idx", idx, 0);
      chk("rst_blk", blk, 0);
      chk("rst_bits", bits, 0);

      // acquire lock starting at phase 3
      ph = 3;
      repeat (3) send_good();
      chk("lock_after3", lock, 0);
      chk("idx_after3", idx, 0);
      send_good();
      chk("lock_after4", lock, 1);
      chk("idx_after4", idx, 1);
      chk("lock_blk0", blk, 0);
      chk("lock_bits0", bits, 0);

      // single-bit data error
      send_err(pat[1] ^ 64'h1, 2'b01);
      chk("bit0_err", perr, 1);
      chk("bit0_blk", blk, 1);
      chk("bit0_bits", bits, 1);
      chk("bit0_lock", lock, 1);
      send_good();
      chk("bit0_pulse_end", perr, 0);
      chk("bit0_blk_hold", blk, 1);

      // bad header plus AAAA in place of 5555: 64 + 2 bits
      while (ph != 2) send_good();
      send_err(pat[3], 2'b10);
      chk("hdr_err", perr, 1);
      chk("hdr_blk", blk, 2);
      chk("hdr_bits", bits, 67);
      chk("hdr_lock", lock, 1);

      // stall five cycles
      repeat (5) step(64'hDEAD_BEEF_DEAD_BEEF, 2'b00, 1'b0);
      chk("stall_idx", idx, 3);
      chk("stall_err", perr, 0);
      chk("stall_lock", lock, 1);
      chk("stall_blk", blk, 2);
      send_good();
      chk("post_stall_err", perr, 0);
      chk("post_stall_idx", idx, 4);

      // four garbage blocks drop lock
      for (int i = 0; i < 4; i++) begin
         send_err(64'h0123_4567_89AB_CDE0 ^ 64'(i), 2'b00);
         if (i == 2) chk("garb_lock_held", lock, 1);
      end
      chk("garb_lock_lost", lock, 0);
      chk("garb_blk", blk, 64'(exp_blk));
      chk("garb_bits", bits, 64'(exp_bits));

      // relock
      repeat (3) send_good();
      chk("relock_after3", lock, 0);
      send_good();
      chk("relock_after4", lock, 1);
      chk("relock_blk", blk, 64'(exp_blk));

      // enable low forces hunt, counters hold, no pulse even on a bad word
      cfg_enable = 1'b0;
      step(64'h1111_2222_3333_4444, 2'b00, 1'b1);
      cfg_enable = 1'b1;
      chk("dis_lock", lock, 0);
      chk("dis_err", perr, 0);
      chk("dis_blk", blk, 64'(exp_blk));
      repeat (4) send_good();
      chk("en_relock", lock, 1);

      // mid-run reset
      rx_rst = 1'b1;
      step(pat[ph], 2'b01, 1'b1);
      rx_rst = 1'b0;
      chk("mrst_lock", lock, 0);
      chk("mrst_blk", blk, 0);
      chk("mrst_bits", bits, 0);
      chk("mrst_idx", idx, 0);

      // saturation on the 4-bit-counter instance
      repeat (4) send_good();
      chk("sat_lock", s_lock, 1);
      for (int i = 0; i < 20; i++) send_err(pat[ph] ^ (64'h1 << i), 2'b01);
      chk("sat_blk", s_blk, 15);
      chk("sat_bits", s_bits, 15);
      chk("sat_lock_held", s_lock, 1);
      clear_counts = 1'b1;
      send_err(pat[ph] ^ 64'h8000_0000_0000_0000, 2'b01);
      clear_counts = 1'b0;
      chk("clr_err_pulse", s_perr, 1);
      chk("clr_blk", s_blk, 0);
      chk("clr_bits", s_bits, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
